// File: rtl/pb_debounce_repeat.sv
// Push-button conditioner: 2-FF synchroniser, counter debounce, registered
// press/release pulses and optional auto-repeat while the button is held.
module pb_debounce_repeat #(
    parameter int DB_TICKS   = 500000,
    parameter int RPT_DLY    = 25000000,
    parameter int RPT_PER    = 5000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_in,
    input  logic rpt_en,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW      = $clog2(DB_TICKS + 1);
    localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int TW      = $clog2(RPT_MAX + 1);

    localparam logic [CW-1:0] DB_LAST  = CW'(DB_TICKS - 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(RPT_DLY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(RPT_PER - 1);
    localparam logic          REL_LVL  = ACTIVE_LOW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REPEAT
    } state_t;

    logic [1:0]    sync_q;
    logic          synced;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {REL_LVL, REL_LVL};
        end else begin
            sync_q <= {sync_q[0], pb_in};
        end
    end

    assign synced = sync_q[1] ^ REL_LVL;

    // Any sample agreeing with the accepted level restarts the stability window.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (synced == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            db_d  = ~db_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    // Release is tested before timer expiry so it always wins a collision.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (db_q) begin
                    state_d   = S_HOLD;
                    pressed_d = 1'b1;
                    press_d   = 1'b1;
                end
            end
            S_HOLD: begin
                if (!db_q) begin
                    state_d   = S_IDLE;
                    pressed_d = 1'b0;
                    release_d = 1'b1;
                    timer_d   = '0;
                end else if (!rpt_en) begin
                    timer_d = '0;
                end else if (timer_q == DLY_LAST) begin
                    state_d = S_REPEAT;
                    press_d = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_REPEAT: begin
                if (!db_q) begin
                    state_d   = S_IDLE;
                    pressed_d = 1'b0;
                    release_d = 1'b1;
                    timer_d   = '0;
                end else if (!rpt_en) begin
                    state_d = S_HOLD;
                    timer_d = '0;
                end else if (timer_q == PER_LAST) begin
                    press_d = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                timer_d   = '0;
                pressed_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_pb_debounce_repeat.sv
// Bench for pb_debounce_repeat: active-low and active-high instances driven by
// mirrored buttons, checked every cycle against a window/elapsed-time model.
module tb_pb_debounce_repeat;

    localparam int DB_TICKS = 4;
    localparam int RPT_DLY  = 10;
    localparam int RPT_PER  = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic pb;
    logic pb_b;
    logic rpt_en;
    logic pressed_a, ppulse_a, rpulse_a;
    logic pressed_b, ppulse_b, rpulse_b;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_no = 0;
    int pp_times[$];
    int rp_times[$];

    assign pb_b = ~pb;

    always #5 clk = ~clk;

    pb_debounce_repeat #(
        .DB_TICKS(DB_TICKS), .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .pb_in(pb), .rpt_en(rpt_en),
        .pressed(pressed_a), .press_pulse(ppulse_a), .release_pulse(rpulse_a)
    );

    pb_debounce_repeat #(
        .DB_TICKS(DB_TICKS), .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pb_in(pb_b), .rpt_en(rpt_en),
        .pressed(pressed_b), .press_pulse(ppulse_b), .release_pulse(rpulse_b)
    );

    // Reference model: accepted level flips once DB_TICKS consecutive synchronised
    // samples disagree with it; outputs follow one edge later.
    bit hist[$];
    bit m_lvl, m_held, m_first, m_pp, m_rp;
    int m_gap;

    task automatic model_reset();
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
        m_lvl = 0; m_held = 0; m_first = 1; m_gap = 0; m_pp = 0; m_rp = 0;
    endtask

    task automatic model_step(bit raw, bit en);
        bit all_diff;
        int n;
        hist.push_back(raw);
        m_pp = 0;
        m_rp = 0;
        if (!m_held && m_lvl) begin
            m_held = 1; m_pp = 1; m_gap = 0; m_first = 1;
        end else if (m_held && !m_lvl) begin
            m_held = 0; m_rp = 1;
        end else if (m_held) begin
            if (!en) begin
                m_gap = 0; m_first = 1;
            end else begin
                m_gap++;
                if (m_gap == (m_first ? RPT_DLY : RPT_PER)) begin
                    m_pp = 1; m_gap = 0; m_first = 0;
                end
            end
        end
        n = hist.size();
        if (n >= DB_TICKS + 2) begin
            all_diff = 1;
            for (int i = n - 2 - DB_TICKS; i <= n - 3; i++)
                if (hist[i] == m_lvl) all_diff = 0;
            if (all_diff) m_lvl = ~m_lvl;
        end
    endtask

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_no, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(~pb, rpt_en);
        edge_no++;
        #1;
        check_eq("pressed_a", 32'(pressed_a), 32'(m_held));
        check_eq("ppulse_a",  32'(ppulse_a),  32'(m_pp));
        check_eq("rpulse_a",  32'(rpulse_a),  32'(m_rp));
        check_eq("pressed_b", 32'(pressed_b), 32'(m_held));
        check_eq("ppulse_b",  32'(ppulse_b),  32'(m_pp));
        check_eq("rpulse_b",  32'(rpulse_b),  32'(m_rp));
        if (ppulse_a) pp_times.push_back(edge_no);
        if (rpulse_a) rp_times.push_back(edge_no);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic release_btn();
        pb = 1'b1;
        rpt_en = 1'b0;
        run(12);
    endtask

    initial begin
        int mark;
        int len;
        rst_n  = 1'b0;
        pb     = 1'b1;
        rpt_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pressed_a", 32'(pressed_a), 0);
        check_eq("rst_ppulse_a",  32'(ppulse_a),  0);
        check_eq("rst_rpulse_a",  32'(rpulse_a),  0);
        check_eq("rst_pressed_b", 32'(pressed_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(4);

        // Clean press, no repeat
        pp_times.delete();
        pb = 1'b0;
        mark = edge_no;
        run(107);
        check_eq("c1_count", pp_times.size(), 1);
        check_eq("c1_lat", (pp_times.size() > 0) ? pp_times[0] - mark : -1, 7);
        rp_times.delete();
        release_btn();
        check_eq("c1_release", rp_times.size(), 1);

        // Bounce shorter than the window
        pp_times.delete();
        for (int k = 0; k < 10; k++) begin
            pb = (k % 2 == 0) ? 1'b0 : 1'b1;
            run(2);
        end
        check_eq("c2_no_pulse", pp_times.size(), 0);
        pb = 1'b0;
        mark = edge_no;
        run(20);
        check_eq("c2_count", pp_times.size(), 1);
        check_eq("c2_lat", (pp_times.size() > 0) ? pp_times[0] - mark : -1, 7);
        release_btn();

        // Auto-repeat, then release
        pp_times.delete();
        rp_times.delete();
        rpt_en = 1'b1;
        pb = 1'b0;
        run(47);
        pb = 1'b1;
        run(10);
        check_eq("c3_count", pp_times.size(), 14);
        check_eq("c3_dly", (pp_times.size() > 2) ? pp_times[1] - pp_times[0] : -1, RPT_DLY);
        check_eq("c3_per", (pp_times.size() > 2) ? pp_times[2] - pp_times[1] : -1, RPT_PER);
        check_eq("c3_release", rp_times.size(), 1);
        release_btn();

        // Release collides with the first repeat expiry
        rpt_en = 1'b1;
        pb = 1'b0;
        run(10);
        pb = 1'b1;
        run(7);
        check_eq("c4_rel", 32'(rpulse_a), 1);
        check_eq("c4_nopp", 32'(ppulse_a), 0);
        check_eq("c4_idle", 32'(pressed_a), 0);
        release_btn();

        // rpt_en dropped on a repeat expiry, later re-raised
        pp_times.delete();
        rpt_en = 1'b1;
        pb = 1'b0;
        run(22);
        check_eq("c5_before", pp_times.size(), 3);
        rpt_en = 1'b0;
        run(10);
        check_eq("c5_stopped", pp_times.size(), 3);
        pp_times.delete();
        rpt_en = 1'b1;
        mark = edge_no;
        run(12);
        check_eq("c5_rearm", (pp_times.size() > 0) ? pp_times[0] - mark : -1, RPT_DLY);
        release_btn();

        // Reset while held
        pb = 1'b0;
        run(12);
        check_eq("c6_held", 32'(pressed_a), 1);
        rst_n = 1'b0;
        #1;
        check_eq("c6_async_a", 32'(pressed_a), 0);
        check_eq("c6_async_b", 32'(pressed_b), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pp_times.delete();
        mark = edge_no;
        run(12);
        check_eq("c6_count", pp_times.size(), 1);
        check_eq("c6_lat", (pp_times.size() > 0) ? pp_times[0] - mark : -1, 7);
        release_btn();

        // Randomised button activity
        for (int s = 0; s < 200; s++) begin
            pb = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rpt_en = ~rpt_en;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6);
            run(len);
        end
        release_btn();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
